// File: rtl/fpga_row_cfg_loader_pkg.sv
// Shared definitions for the row configuration loader: sync byte, derived widths
// and FSM encoding, reused by the array-level loader.
package fpga_row_cfg_loader_pkg;

    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_e;

    function automatic int unsigned brb_w(input int unsigned fw, input int unsigned ww);
        return fw * ww * 12;
    endfunction

    function automatic int unsigned bsb_w(input int unsigned fw, input int unsigned ww);
        return (fw - 1) * ww * ww * 12;
    endfunction

    function automatic int unsigned lb_w(input int unsigned fw);
        return (fw - 1) * 5;
    endfunction

    function automatic int unsigned cfg_w(input int unsigned fw, input int unsigned ww);
        return brb_w(fw, ww) + bsb_w(fw, ww) + lb_w(fw);
    endfunction

    function automatic int unsigned nb(input int unsigned fw, input int unsigned ww);
        return (cfg_w(fw, ww) + 7) / 8;
    endfunction

endpackage

// File: rtl/fpga_row_cfg_loader.sv
// Loads one FPGA row's routing/logic configuration from a byte stream framed as
// sync, payload, XOR checksum; active selects update only on a verified frame.
module fpga_row_cfg_loader
    import fpga_row_cfg_loader_pkg::*;
#(
    parameter int unsigned wire_width = 3,
    parameter int unsigned fpga_width = 5
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           cfg_valid,
    input  logic [7:0]                                     cfg_data,
    output logic                                           cfg_ready,
    output logic [brb_w(fpga_width, wire_width)-1:0]       brbselect,
    output logic [bsb_w(fpga_width, wire_width)-1:0]       bsbselect,
    output logic [lb_w(fpga_width)-1:0]                    lbselect,
    output logic                                           cfg_loaded,
    output logic                                           cfg_done,
    output logic                                           cfg_error
);

    localparam int unsigned BRB_W = brb_w(fpga_width, wire_width);
    localparam int unsigned BSB_W = bsb_w(fpga_width, wire_width);
    localparam int unsigned LB_W  = lb_w(fpga_width);
    localparam int unsigned NB    = nb(fpga_width, wire_width);
    localparam int unsigned SH_W  = NB * 8;
    localparam int unsigned CNT_W = $clog2(NB + 1);

    cfg_state_e        state;
    cfg_state_e        state_d;
    logic [SH_W-1:0]   shadow;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        csum;
    logic              accept;
    logic              sync_hit;
    logic              load_hit;
    logic              err_hit;

    // Next-state and datapath strobes
    always_comb begin
        state_d  = state;
        accept   = cfg_valid && cfg_ready;
        sync_hit = 1'b0;
        load_hit = 1'b0;
        err_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (cfg_data == SYNC)) begin
                    sync_hit = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    load_hit = 1'b1;
                    if (cnt == CNT_W'(NB - 1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (cfg_data == csum) begin
                        state_d = COMMIT;
                    end else begin
                        err_hit = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Shadow capture, running checksum, and the commit into the active selects
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            csum       <= '0;
            shadow     <= '0;
            brbselect  <= '0;
            bsbselect  <= '0;
            lbselect   <= '0;
            cfg_ready  <= 1'b0;
            cfg_loaded <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
        end else begin
            cfg_ready <= (state_d != COMMIT);
            cfg_done  <= (state == COMMIT);
            cfg_error <= err_hit;
            if (sync_hit) begin
                cnt  <= '0;
                csum <= '0;
            end
            if (load_hit) begin
                shadow[{cnt, 3'b000} +: 8] <= cfg_data;
                csum                       <= csum ^ cfg_data;
                cnt                        <= cnt + CNT_W'(1);
            end
            if (state == COMMIT) begin
                brbselect  <= shadow[BRB_W-1:0];
                bsbselect  <= shadow[BRB_W +: BSB_W];
                lbselect   <= shadow[BRB_W + BSB_W +: LB_W];
                cfg_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpga_row_cfg_loader.sv
// Self-checking bench for fpga_row_cfg_loader: table of frames plus hand-written
// reset and back-to-back sequences, checked by a scoreboard on cfg_done/cfg_error.
module tb_fpga_row_cfg_loader;

    localparam int NB  = 79;
    localparam int BRB = 180;
    localparam int BSB = 432;
    localparam int LB  = 20;
    localparam int CW  = 632;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [7:0]     cfg_data = 8'h00;
    logic           cfg_ready;
    logic [BRB-1:0] brbselect;
    logic [BSB-1:0] bsbselect;
    logic [LB-1:0]  lbselect;
    logic           cfg_loaded;
    logic           cfg_done;
    logic           cfg_error;

    fpga_row_cfg_loader #(.wire_width(3), .fpga_width(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .brbselect (brbselect),
        .bsbselect (bsbselect),
        .lbselect  (lbselect),
        .cfg_loaded(cfg_loaded),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit             err;
        logic [BRB-1:0] brb;
        logic [BSB-1:0] bsb;
        logic [LB-1:0]  lb;
        logic [7:0]     b0;
        logic           loaded;
    } exp_t;

    typedef struct {
        int         pat;
        int         duty;
        bit         bad;
        bit         garbage;
        bit         exp_err;
        logic [7:0] exp_b0;
    } vec_t;

    exp_t           sbq[$];
    vec_t           vecs[6];
    logic [7:0]     pay[NB];
    logic [BRB-1:0] cur_brb = '0;
    logic [BSB-1:0] cur_bsb = '0;
    logic [LB-1:0]  cur_lb = '0;
    logic           cur_loaded = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int exp_done = 0;
    int cs_acc = 0;
    int last_acc = 0;
    bit ready_armed = 1'b0;
    bit prev_ready_low = 1'b0;

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int p, input int i);
        case (p)
            0:       return 8'(i + 1);
            1:       return 8'(255 - i);
            default: return 8'(i * 37 + 5);
        endcase
    endfunction

    task automatic fill(input int p);
        for (int i = 0; i < NB; i++) pay[i] = pat_byte(p, i);
    endtask

    // Independent bitwise model of the LSB-first payload mapping
    task automatic build_exp(output exp_t e, input logic [7:0] b0);
        logic [CW-1:0] v;
        for (int k = 0; k < CW; k++) v[k] = pay[k / 8][k % 8];
        e.err    = 1'b0;
        e.brb    = v[BRB-1:0];
        e.bsb    = v[BRB +: BSB];
        e.lb     = v[BRB + BSB +: LB];
        e.b0     = b0;
        e.loaded = 1'b1;
    endtask

    // Offer one byte after random idle gaps; returns just after the accepting edge
    task automatic send(input logic [7:0] b, input int duty);
        while (duty < 100 && int'($urandom_range(99)) >= duty) begin
            cfg_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b1;
        cfg_data  = b;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            if (cfg_ready) begin
                @(posedge clk);
                #1;
                cfg_valid = 1'b0;
                last_acc  = cyc;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: byte %0h not accepted within 8 cycles", b);
        cfg_valid = 1'b0;
    endtask

    task automatic send_frame(input bit bad, input bit exp_err, input int duty, input logic [7:0] b0);
        logic [7:0] x;
        exp_t       e;
        x = 8'h00;
        send(8'hA5, duty);
        for (int i = 0; i < NB; i++) begin
            send(pay[i], duty);
            x = x ^ pay[i];
        end
        if (exp_err) begin
            e.err    = 1'b1;
            e.brb    = cur_brb;
            e.bsb    = cur_bsb;
            e.lb     = cur_lb;
            e.b0     = b0;
            e.loaded = cur_loaded;
        end else begin
            build_exp(e, b0);
            cur_brb    = e.brb;
            cur_bsb    = e.bsb;
            cur_lb     = e.lb;
            cur_loaded = 1'b1;
            exp_done++;
        end
        sbq.push_back(e);
        send(bad ? (x ^ 8'h01) : x, duty);
        cs_acc = last_acc;
    endtask

    // Scoreboard monitor and ready-protocol check, sampled on the falling edge
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            ready_armed    = 1'b0;
            prev_ready_low = 1'b0;
        end else begin
            if (prev_ready_low) chk("ready_low_only_in_commit", 640'(cfg_done), 640'(1));
            prev_ready_low = ready_armed && !cfg_ready;
            if (cfg_ready) ready_armed = 1'b1;
            if (cfg_done || cfg_error) begin
                chk("done_error_exclusive", 640'(cfg_done && cfg_error), 640'(0));
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: done=%0b error=%0b with no frame pending",
                             cfg_done, cfg_error);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_kind_error", 640'(cfg_error), 640'(e.err));
                    chk("pulse_latency", 640'(cyc), 640'(e.err ? cs_acc : cs_acc + 1));
                    chk("brbselect", 640'(brbselect), 640'(e.brb));
                    chk("bsbselect", 640'(bsbselect), 640'(e.bsb));
                    chk("lbselect", 640'(lbselect), 640'(e.lb));
                    chk("brbselect_lo_byte", 640'(brbselect[7:0]), 640'(e.b0));
                    chk("cfg_loaded", 640'(cfg_loaded), 640'(e.loaded));
                    if (cfg_done) n_done++;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{pat: 0, duty: 100, bad: 1'b1, garbage: 1'b0, exp_err: 1'b1, exp_b0: 8'h00};
        vecs[1] = '{pat: 0, duty: 100, bad: 1'b0, garbage: 1'b0, exp_err: 1'b0, exp_b0: 8'h01};
        vecs[2] = '{pat: 1, duty: 100, bad: 1'b0, garbage: 1'b1, exp_err: 1'b0, exp_b0: 8'hFF};
        vecs[3] = '{pat: 2, duty: 30,  bad: 1'b0, garbage: 1'b0, exp_err: 1'b0, exp_b0: 8'h05};
        vecs[4] = '{pat: 0, duty: 30,  bad: 1'b0, garbage: 1'b0, exp_err: 1'b0, exp_b0: 8'h01};
        vecs[5] = '{pat: 1, duty: 100, bad: 1'b1, garbage: 1'b0, exp_err: 1'b1, exp_b0: 8'h01};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 640'(cfg_ready), 640'(0));
        chk("reset_loaded", 640'(cfg_loaded), 640'(0));
        chk("reset_brb", 640'(brbselect), 640'(0));
        chk("reset_pulses", 640'({cfg_done, cfg_error}), 640'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", 640'(cfg_ready), 640'(1));
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].pat);
            if (vecs[v].garbage) begin
                send(8'h00, 100);
                send(8'hFF, 100);
            end
            send_frame(vecs[v].bad, vecs[v].exp_err, vecs[v].duty, vecs[v].exp_b0);
        end

        // Reset in the middle of a frame, then a complete new frame
        fill(0);
        send(8'hA5, 100);
        for (int i = 0; i < 40; i++) send(pay[i], 100);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_brb", 640'(brbselect), 640'(0));
        chk("midreset_bsb", 640'(bsbselect), 640'(0));
        chk("midreset_lb", 640'(lbselect), 640'(0));
        chk("midreset_loaded", 640'(cfg_loaded), 640'(0));
        chk("midreset_ready", 640'(cfg_ready), 640'(0));
        cur_brb    = '0;
        cur_bsb    = '0;
        cur_lb     = '0;
        cur_loaded = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill(2);
        send_frame(1'b0, 1'b0, 100, 8'h05);

        // Back-to-back frames A then B
        fill(1);
        send_frame(1'b0, 1'b0, 100, 8'hFF);
        fill(0);
        send_frame(1'b0, 1'b0, 100, 8'h01);

        repeat (5) @(negedge clk);
        chk("queue_drained", 640'(sbq.size()), 640'(0));
        chk("done_count", 640'(n_done), 640'(exp_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_row_cfg_loader.md
FPGA_ROW_CFG_LOADER -- requirements
Module: fpga_row_cfg_loader

Interface
REQ-001 The block SHALL have parameter wire_width, default 3: routing channel width per row.
REQ-002 The block SHALL have parameter fpga_width, default 5: number of routing columns per row.
REQ-003 The block SHALL derive these widths:
- BRB_W = fpga_width*wire_width*12
- BSB_W = (fpga_width-1)*wire_width*wire_width*12
- LB_W = (fpga_width-1)*5
- CFG_W = BRB_W+BSB_W+LB_W
- NB = ceil(CFG_W/8), which is 79 at defaults.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: byte offered on cfg_data.
REQ-007 The block SHALL have port cfg_data, input, 8 bits: bitstream byte.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: byte accepted when cfg_valid and cfg_ready are both high at a clk edge.
REQ-009 The block SHALL have port brbselect, output, BRB_W bits: active routing-block selects for the row.
REQ-010 The block SHALL have port bsbselect, output, BSB_W bits: active switch-block selects.
REQ-011 The block SHALL have port lbselect, output, LB_W bits: active logic-block configuration.
REQ-012 The block SHALL have port cfg_loaded, output, 1 bit: level, high once any frame has committed.
REQ-013 The block SHALL have port cfg_done, output, 1 bit: one-cycle pulse on commit.
REQ-014 The block SHALL have port cfg_error, output, 1 bit: one-cycle pulse on checksum mismatch.

Function
REQ-015 The frame format SHALL be: sync byte 0xA5, then NB payload bytes, then one checksum byte equal to the XOR of all NB payload bytes.
REQ-016 Payload SHALL be LSB-first. Payload bit k is bit (k mod 8) of payload byte floor(k/8).
REQ-017 Concatenated payload bits SHALL map as follows; pad bits at or above CFG_W are ignored.
- bits [BRB_W-1:0] go to brbselect.
- the next BSB_W bits go to bsbselect.
- the next LB_W bits go to lbselect.
REQ-018 The FSM SHALL have four states: IDLE, LOAD, CHECK, COMMIT.
REQ-019 In IDLE, an accepted 0xA5 SHALL move the FSM to LOAD and clear the byte counter and running checksum; any other accepted byte SHALL be discarded and the FSM stays in IDLE.
REQ-020 In LOAD, each accepted byte SHALL be written into the shadow register at byte slot = byte counter. Each such byte SHALL also be XORed into the running checksum and SHALL increment the counter.
REQ-021 After the NB-th payload byte is accepted, the FSM SHALL move to CHECK.
REQ-022 In CHECK, the accepted byte SHALL be compared with the running checksum.
- Match: next state is COMMIT.
- Mismatch: cfg_error pulses high in the following cycle, the next state is IDLE, and the active outputs stay unchanged.
REQ-023 In COMMIT, which lasts exactly one cycle, the shadow SHALL be copied to brbselect, bsbselect and lbselect. In that same cycle cfg_done SHALL be high and cfg_loaded SHALL be set; the next state is IDLE.
REQ-024 Latency SHALL be fixed: with the checksum accepted at edge T, the outputs SHALL change, and cfg_done be visible, after edge T+1.
REQ-025 cfg_ready SHALL be high in IDLE, LOAD and CHECK, and low in COMMIT.
REQ-026 cfg_ready SHALL NOT depend combinationally on cfg_valid.
REQ-027 Active outputs SHALL change only in COMMIT. A partial or failed frame SHALL never alter them.
REQ-028 Gaps with cfg_valid low SHALL be permitted at any position in a frame, with no timeout.
REQ-029 A 0xA5 byte arriving in LOAD or CHECK SHALL be treated as data, not as a resync.
REQ-030 The byte counter SHALL be ceil(log2(NB+1)) bits wide and SHALL NOT wrap within a frame.
REQ-031 cfg_done and cfg_error SHALL never be high in the same cycle.

Reset
REQ-032 While rst_n is low at a clk edge, the following SHALL be set:
- FSM to IDLE.
- counter, checksum and shadow to 0.
- brbselect, bsbselect, lbselect to all-zero.
- cfg_loaded, cfg_done and cfg_error to 0.
- cfg_ready to 0 during reset; it is 1 in the first cycle after rst_n goes high.
REQ-033 A reset mid-frame SHALL discard the partial frame, so that the next frame must begin with 0xA5.

Structure
REQ-034 A shared package SHALL hold:
- the SYNC byte constant 0xA5;
- the BRB_W, BSB_W, LB_W, CFG_W and NB width functions;
- the FSM state encoding, for reuse by the array-level loader.
REQ-035 The block SHALL be a single module with no sub-module. The checksum and byte-slot write are inline logic.

Verification
REQ-036 The bench SHALL cover a clean frame at default parameters:
- Stimulus: 0xA5, 79 bytes 0x01..0x4F, correct XOR.
- Required: cfg_done pulses once, one cycle after the checksum. brbselect[7:0]=0x01, lbselect matches the final payload bits, and cfg_loaded=1.
REQ-037 The bench SHALL cover a bad checksum:
- Stimulus: the same frame with checksum^0x01.
- Required: cfg_error pulses once, cfg_done stays 0, and the outputs keep their prior values (all-zero after reset).
REQ-038 The bench SHALL cover leading garbage:
- Stimulus: 0x00, 0xFF, then a valid frame.
- Required: garbage is ignored and the frame commits normally.
REQ-039 The bench SHALL cover a throttled source:
- Stimulus: cfg_valid random at 30% duty during a valid frame.
- Required: identical committed outputs, and cfg_ready low only in the COMMIT cycle.
REQ-040 The bench SHALL cover reset mid-frame:
- Stimulus: rst_n low after payload byte 40, then a full new frame.
- Required: the outputs are zero after reset and afterwards hold exactly the new frame's contents.
REQ-041 The bench SHALL cover back-to-back frames:
- Stimulus: frame A, then frame B with no idle cycles other than COMMIT.
- Required: two cfg_done pulses, with the outputs equal to A and then B.
